// File: rtl/keypad_scanner_if.sv
// Key report channel between the keypad scanner and the register/bus logic that consumes key codes.
interface keypad_scanner_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_held;
   logic       overrun;

   modport master (
      output key_code,
      output key_valid,
      output key_held,
      output overrun,
      input  key_ack
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  key_held,
      input  overrun,
      output key_ack
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, whole-scan debounce,
// and a valid/ack key report with sticky overrun.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | debounced: no key down
// ST_HELD | debounced: exactly one key down, its code in held_code_q
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 100_000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   keypad_scanner_if.master kif
);
   localparam int         DW       = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DWELL_TC = DW'(SCAN_DIV - 1);
   localparam logic [3:0] DEB_N    = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
   typedef enum logic {ST_IDLE, ST_HELD} state_t;

   logic [3:0]    row_m_q, row_s_q;
   logic [DW-1:0] dwell_q;
   logic [1:0]    col_idx_q;
   logic [1:0]    acc_cnt_q;
   logic [3:0]    acc_code_q;
   logic          res_valid_q;
   res_t          res_kind_q;
   logic [3:0]    res_code_q;
   res_t          cand_kind_q;
   logic [3:0]    cand_code_q;
   logic [3:0]    cnt_q;
   logic          stab_q;
   state_t        state_q, state_d;
   logic [3:0]    held_code_q, held_code_d;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;
   logic          press_evt;

   logic       sample;
   logic [3:0] row_low;
   logic [2:0] n_low, acc_sum;
   logic [1:0] first_row, acc_cnt_new;
   logic [3:0] acc_code_new, cnt_inc;
   logic       cand_match;

   assign col_o  = ~(4'b0001 << col_idx_q);
   assign sample = en_i && (dwell_q == DWELL_TC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_m_q <= 4'hF;
         row_s_q <= 4'hF;
      end else begin
         row_m_q <= row_i;
         row_s_q <= row_m_q;
      end
   end

   always_comb begin
      row_low   = ~row_s_q;
      n_low     = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
      first_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (row_low[i]) first_row = 2'(i);
      end
      acc_sum      = {1'b0, acc_cnt_q} + n_low;
      acc_cnt_new  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
      acc_code_new = (acc_cnt_q == 2'd0 && n_low != 3'd0) ? {first_row, col_idx_q} : acc_code_q;
   end

   // Column sequencer and per-scan accumulator; acc_cnt saturates at 2 (= MULTI).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_q     <= '0;
         col_idx_q   <= 2'd0;
         acc_cnt_q   <= 2'd0;
         acc_code_q  <= 4'd0;
         res_valid_q <= 1'b0;
         res_kind_q  <= RES_NONE;
         res_code_q  <= 4'd0;
      end else if (en_i) begin
         res_valid_q <= sample && (col_idx_q == 2'd3);
         if (sample) begin
            dwell_q   <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            if (col_idx_q == 2'd3) begin
               res_kind_q <= (acc_cnt_new == 2'd0) ? RES_NONE :
                             (acc_cnt_new == 2'd1) ? RES_SINGLE : RES_MULTI;
               res_code_q <= acc_code_new;
               acc_cnt_q  <= 2'd0;
               acc_code_q <= 4'd0;
            end else begin
               acc_cnt_q  <= acc_cnt_new;
               acc_code_q <= acc_code_new;
            end
         end else begin
            dwell_q <= dwell_q + 1'b1;
         end
      end
   end

   assign cand_match = (cand_kind_q == res_kind_q) &&
                       (res_kind_q == RES_NONE || cand_code_q == res_code_q);
   assign cnt_inc    = (cnt_q == DEB_N) ? cnt_q : cnt_q + 4'd1;

   // Candidate RES_MULTI doubles as "no valid candidate".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand_kind_q <= RES_MULTI;
         cand_code_q <= 4'd0;
         cnt_q       <= 4'd0;
         stab_q      <= 1'b0;
      end else if (en_i) begin
         stab_q <= 1'b0;
         if (res_valid_q) begin
            if (res_kind_q == RES_MULTI) begin
               cand_kind_q <= RES_MULTI;
               cnt_q       <= 4'd0;
            end else if (cand_match) begin
               cnt_q  <= cnt_inc;
               stab_q <= (cnt_inc == DEB_N) && (cnt_q != DEB_N);
            end else begin
               cand_kind_q <= res_kind_q;
               cand_code_q <= res_code_q;
               cnt_q       <= 4'd1;
               stab_q      <= (DEB_N == 4'd1);
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      held_code_d = held_code_q;
      press_evt   = 1'b0;
      code_d      = code_q;
      valid_d     = valid_q;
      ovr_d       = ovr_q;
      if (stab_q && en_i) begin
         if (cand_kind_q == RES_SINGLE) begin
            press_evt   = (state_q == ST_IDLE) || (held_code_q != cand_code_q);
            state_d     = ST_HELD;
            held_code_d = cand_code_q;
         end else if (cand_kind_q == RES_NONE) begin
            state_d = ST_IDLE;
         end
      end
      if (press_evt) begin
         if (!valid_q) begin
            code_d  = held_code_d;
            valid_d = 1'b1;
         end else if (!kif.key_ack) begin
            ovr_d = 1'b1;
         end else begin
            code_d = held_code_d;
            ovr_d  = 1'b0;
         end
      end else if (kif.key_ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         held_code_q <= 4'd0;
         code_q      <= 4'd0;
         valid_q     <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_code_q <= held_code_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         ovr_q       <= ovr_d;
      end
   end

   assign kif.key_code  = code_q;
   assign kif.key_valid = valid_q;
   assign kif.key_held  = (state_q == ST_HELD);
   assign kif.overrun   = ovr_q;
endmodule
